// File: rtl/dcache_fill_ctrl.sv
// Data-cache line fill controller: bus read of the missing line, fill strobe, optional victim writeback.
// Latency: bus_req 1 cycle after miss accept; mem_wren 1 cycle after read bus_ack; stalls until bus_ack or timeout.
// Backpressure: miss_req is held by the cache until miss_ack; bus requests are held until bus_ack or ACK_TIMEOUT.
module dcache_fill_ctrl #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        miss_req_i,
    input  logic [14:0] miss_addr_i,
    output logic        miss_ack_o,
    output logic        mem_wren_o,
    output logic [14:0] mem_wraddr_o,
    output logic [63:0] mem_wrdata_o,
    input  logic        evict_i,
    input  logic [14:0] evict_addr_i,
    input  logic [63:0] evict_data_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [14:0] bus_addr_o,
    output logic [63:0] bus_wdata_o,
    input  logic [63:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        busy_o,
    output logic        bus_err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_FILL,
        S_EVCHK,
        S_WB
    } state_e;

    localparam logic [14:0] LINE_MASK = 15'h7FF8;
    localparam logic [7:0]  TMO       = 8'(ACK_TIMEOUT);

    state_e      state_q, state_d;
    logic [14:0] addr_q, addr_d;
    logic [63:0] line_q, line_d;
    logic [63:0] wb_data_q, wb_data_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [14:0] bus_addr_q, bus_addr_d;
    logic        bus_err_q, bus_err_d;
    logic        miss_ack;
    logic        mem_wren;
    logic        ack_ok;
    logic [7:0]  cnt_inc;

    // An ack only counts while a request is actually on the bus.
    assign ack_ok  = bus_ack_i & bus_req_q;
    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        line_d     = line_q;
        wb_data_d  = wb_data_q;
        cnt_d      = cnt_q;
        bus_req_d  = bus_req_q;
        bus_we_d   = bus_we_q;
        bus_addr_d = bus_addr_q;
        bus_err_d  = 1'b0;
        miss_ack   = 1'b0;
        mem_wren   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (miss_req_i) begin
                    miss_ack   = 1'b1;
                    addr_d     = miss_addr_i & LINE_MASK;
                    bus_addr_d = miss_addr_i & LINE_MASK;
                    bus_req_d  = 1'b1;
                    bus_we_d   = 1'b0;
                    cnt_d      = 8'd0;
                    state_d    = S_RD;
                end
            end
            S_RD: begin
                if (ack_ok) begin
                    line_d    = bus_rdata_i;
                    bus_req_d = 1'b0;
                    state_d   = S_FILL;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TMO) begin
                        bus_err_d = 1'b1;
                        bus_req_d = 1'b0;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_FILL: begin
                mem_wren = 1'b1;
                state_d  = S_EVCHK;
            end
            S_EVCHK: begin
                // Victim info is only valid in the cycle right after the fill strobe.
                if (evict_i) begin
                    bus_addr_d = evict_addr_i & LINE_MASK;
                    wb_data_d  = evict_data_i;
                    bus_req_d  = 1'b1;
                    bus_we_d   = 1'b1;
                    cnt_d      = 8'd0;
                    state_d    = S_WB;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WB: begin
                if (ack_ok) begin
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TMO) begin
                        bus_err_d = 1'b1;
                        bus_req_d = 1'b0;
                        bus_we_d  = 1'b0;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: begin
                bus_req_d = 1'b0;
                bus_we_d  = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            line_q     <= '0;
            wb_data_q  <= '0;
            cnt_q      <= '0;
            bus_req_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_addr_q <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            line_q     <= line_d;
            wb_data_q  <= wb_data_d;
            cnt_q      <= cnt_d;
            bus_req_q  <= bus_req_d;
            bus_we_q   <= bus_we_d;
            bus_addr_q <= bus_addr_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign miss_ack_o   = miss_ack;
    assign mem_wren_o   = mem_wren;
    assign mem_wraddr_o = addr_q;
    assign mem_wrdata_o = line_q;
    assign bus_req_o    = bus_req_q;
    assign bus_we_o     = bus_we_q;
    assign bus_addr_o   = bus_addr_q;
    assign bus_wdata_o  = wb_data_q;
    assign busy_o       = (state_q != S_IDLE);
    assign bus_err_o    = bus_err_q;

endmodule

// File: doc/dcache_fill_ctrl.md
DCACHE_FILL_CTRL -- requirements
Module: dcache_fill_ctrl

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 255, maximum cycles waited for bus_ack before an access is abandoned (range 1..255).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 miss_req  in  1  cache requests a line fill; held until miss_ack.
REQ-005 miss_addr  in  15  byte address of missing line.
REQ-006 miss_ack  out  1  one-cycle pulse, miss accepted.
REQ-007 mem_wren  out  1  one-cycle fill strobe to cache store fill port.
REQ-008 mem_wraddr  out  15  fill line address, bits [2:0] forced 0.
REQ-009 mem_wrdata  out  64  fill line data.
REQ-010 evict  in  1  cache victim-valid flag, valid the cycle after mem_wren.
REQ-011 evict_addr  in  15  victim line address, same timing as evict.
REQ-012 evict_data  in  64  victim line data, same timing as evict.
REQ-013 bus_req  out  1  memory bus access request, held until bus_ack.
REQ-014 bus_we  out  1  1 = write (writeback), 0 = read (fill).
REQ-015 bus_addr  out  15  bus address, bits [2:0] = 0.
REQ-016 bus_wdata  out  64  writeback data.
REQ-017 bus_rdata  in  64  read data, valid with bus_ack.
REQ-018 bus_ack  in  1  one-cycle completion pulse.
REQ-019 busy  out  1  high whenever state is not IDLE.
REQ-020 bus_err  out  1  one-cycle pulse on timeout.

Function
REQ-021 FSM states SHALL be IDLE, RD, FILL, EVCHK, WB.
REQ-022 IDLE: miss_req=1 -> capture {miss_addr[14:3],3'b000} into the address register, pulse miss_ack, go to RD; miss_ack is never asserted outside IDLE.
REQ-023 RD: bus_req=1, bus_we=0, bus_addr=captured address; bus_ack -> latch bus_rdata into the line register and go to FILL.
REQ-024 FILL: mem_wren=1 for exactly one cycle with mem_wraddr=captured address and mem_wrdata=line register; then go to EVCHK.
REQ-025 EVCHK: sample evict, evict_addr and evict_data in this cycle (the cycle after mem_wren). evict=1 -> load the writeback buffer with {evict_addr[14:3],3'b000} and evict_data, then go to WB. evict=0 -> go to IDLE.
REQ-026 WB: bus_req=1, bus_we=1, bus_addr/bus_wdata from the writeback buffer; bus_ack -> IDLE.
REQ-027 Miss-to-miss_ack latency: 1 cycle from miss_req sampled in IDLE. Fill latency: mem_wren is asserted the cycle after the bus_ack of the read.
REQ-028 bus_req, bus_we, bus_addr and bus_wdata SHALL be registered and stable while bus_req=1.
REQ-029 An 8-bit wait counter SHALL clear on entry to RD or WB and increment each cycle without bus_ack. Reaching ACK_TIMEOUT -> pulse bus_err, drop bus_req, go to IDLE.
REQ-030 A timeout in RD SHALL NOT produce mem_wren. A timeout in WB discards the buffered victim.
REQ-031 bus_ack while bus_req=0 SHALL be ignored.
REQ-032 bus_ack in the same cycle the counter reaches ACK_TIMEOUT counts as success, with no bus_err.
REQ-033 miss_req arriving in the cycle the FSM returns to IDLE is accepted on the next edge; no request is dropped while it is held.
REQ-034 Outputs not named active in a state SHALL be 0; data and address outputs hold their last values.

Reset
REQ-035 rst=0 SHALL immediately force IDLE with busy, miss_ack, mem_wren, bus_req, bus_we and bus_err = 0; address, line, buffer and counter registers = 0.
REQ-036 Reset mid-operation SHALL abandon any outstanding bus access or writeback without a fill strobe. After rst rises, the first miss_req is accepted normally.

Verification
REQ-037 Clean fill: miss_req with addr 0x1A4D, bus_ack 3 cycles later with rdata 0xDEADBEEF_00C0FFEE, evict=0 -> bus_addr 0x1A48, mem_wren one cycle with 0x1A48 and that data, then IDLE.
REQ-038 Fill with eviction: as REQ-037 plus evict=1, evict_addr 0x3208, evict_data 0x1122334455667788 in EVCHK -> bus_we=1 write of that data to 0x3208, then busy=0 after bus_ack.
REQ-039 Timeout: ACK_TIMEOUT=4, no bus_ack -> bus_err pulse on the 4th wait cycle, no mem_wren, IDLE.
REQ-040 Back-to-back: miss_req held continuously across two misses -> exactly two miss_ack pulses and two mem_wren pulses, in order.
REQ-041 Reset in WB: rst=0 while bus_req=1 -> bus_req=0 asynchronously; no bus_err pulse.
REQ-042 Spurious ack: bus_ack pulsed in IDLE -> no state change and all outputs remain 0.
